// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage data RAM access controller:
//   - RAM access mode encodings (byte / halfword / word / doubleword)
//   - controller FSM state type
//   - helpers returning the access size and the alignment check for a mode
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] MODE_BYTE  = 2'b00;
    localparam logic [1:0] MODE_HALF  = 2'b01;
    localparam logic [1:0] MODE_WORD  = 2'b10;
    localparam logic [1:0] MODE_DWORD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_GAP   = 3'd2,
        ST_BEAT1 = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Number of bytes touched by an access of the given mode.
    function automatic logic [3:0] size_of_mode(input logic [1:0] mode);
        logic [3:0] size;
        case (mode)
            MODE_BYTE:  size = 4'd1;
            MODE_HALF:  size = 4'd2;
            MODE_WORD:  size = 4'd4;
            MODE_DWORD: size = 4'd8;
            default:    size = 4'd1;
        endcase
        return size;
    endfunction

    // Halfwords need an even address; words and doublewords need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] addr_lo);
        logic mis;
        case (mode)
            MODE_BYTE:  mis = 1'b0;
            MODE_HALF:  mis = addr_lo[0];
            MODE_WORD:  mis = (addr_lo != 2'b00);
            MODE_DWORD: mis = (addr_lo != 2'b00);
            default:    mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces of mem_access_ctrl.
//   mem_access_ctrl_if : pipeline request/response handshake.
//       master = EX/MEM pipeline side, slave = controller.
//   mem_ram_if         : data RAM pin bundle.
//       master = controller, slave = RAM.
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_mode;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_wdata_hi;
    logic        stall;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] rsp_data_hi;

    modport master (
        output req_valid, req_rw, req_mode, req_signed, req_addr, req_wdata, req_wdata_hi,
        input  req_ready, stall, rsp_valid, rsp_err, rsp_data, rsp_data_hi
    );

    modport slave (
        input  req_valid, req_rw, req_mode, req_signed, req_addr, req_wdata, req_wdata_hi,
        output req_ready, stall, rsp_valid, rsp_err, rsp_data, rsp_data_hi
    );
endinterface

interface mem_ram_if;
    logic        ram_en;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [1:0]  ram_mode;
    logic [31:0] ram_dout;

    modport master (
        output ram_en, ram_rw, ram_addr, ram_din, ram_mode,
        input  ram_dout
    );

    modport slave (
        input  ram_en, ram_rw, ram_addr, ram_din, ram_mode,
        output ram_dout
    );
endinterface

// File: rtl/mem_access_ctrl_load_extender.sv
// ---------------------------------------------------------------------------
// load_extender
// Combinational zero/sign extension of raw RAM read data.
//   mode     in  2   access mode (byte/half extend, word/dword pass through)
//   sign_ext in  1   1 = replicate the top data bit, 0 = zero fill
//   raw      in  32  RAM DataOut
//   ext      out 32  extended load value
// ---------------------------------------------------------------------------
module load_extender
    import mem_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic        sign_ext,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Select the fill bit by access width.
    always_comb begin
        ext = raw;
        case (mode)
            MODE_BYTE: ext = {{24{sign_ext & raw[7]}}, raw[7:0]};
            MODE_HALF: ext = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default:   ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage initiator for the data RAM. Accepts one load/store per handshake,
// checks alignment and range, drives the RAM pins (doublewords as two word
// beats separated by an idle cycle), extends load data and returns a single
// cycle response. All outputs are registered.
//   clk     in   system clock
//   clr     in   asynchronous active-low reset
//   req_if  slave  request/response handshake (req_*, rsp_*, stall)
//   ram_if  master data RAM pins (ram_en/rw/addr/din/mode, ram_dout)
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic             clk,
    input  logic             clr,
    mem_access_ctrl_if.slave req_if,
    mem_ram_if.master        ram_if
);

    state_e      state_q, state_d;
    logic        accept_s;

    logic [3:0]  req_size_s;
    logic [32:0] req_last_s;
    logic        req_err_s;

    logic        rw_q, rw_d;
    logic [1:0]  mode_q, mode_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_hi_q, wdata_hi_d;

    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] rsp_data_hi_q, rsp_data_hi_d;

    logic        ram_en_q, ram_en_d;
    logic        ram_rw_q, ram_rw_d;
    logic [1:0]  ram_mode_q, ram_mode_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_din_q, ram_din_d;

    logic [31:0] ext_s;

    load_extender u_load_extender (
        .mode     (mode_q),
        .sign_ext (sgn_q),
        .raw      (ram_if.ram_dout),
        .ext      (ext_s)
    );

    // Request check: the last byte is computed in 33 bits so a high address cannot wrap into range.
    always_comb begin
        req_size_s = size_of_mode(req_if.req_mode);
        req_last_s = {1'b0, req_if.req_addr} + {29'd0, req_size_s} - 33'd1;
        req_err_s  = is_misaligned(req_if.req_mode, req_if.req_addr[1:0])
                     || (req_last_s >= 33'(MEM_BYTES));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; req_valid is only looked at in IDLE.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_if.req_valid) begin
                    accept_s = 1'b1;
                    state_d  = req_err_s ? ST_RESP : ST_BEAT0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_BEAT0: state_d = (mode_q == MODE_DWORD) ? ST_GAP : ST_RESP;
            ST_GAP:   state_d = ST_BEAT1;
            ST_BEAT1: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: outputs are decoded from the state being entered so the
    // registered pins line up with the state they belong to.
    always_comb begin
        rw_d          = rw_q;
        mode_d        = mode_q;
        sgn_d         = sgn_q;
        addr_d        = addr_q;
        wdata_hi_d    = wdata_hi_q;
        rsp_err_d     = rsp_err_q;
        rsp_data_d    = rsp_data_q;
        rsp_data_hi_d = rsp_data_hi_q;
        ram_en_d      = 1'b0;
        ram_rw_d      = 1'b0;
        ram_mode_d    = MODE_BYTE;
        ram_addr_d    = ram_addr_q;
        ram_din_d     = ram_din_q;
        rsp_valid_d   = 1'b0;
        req_ready_d   = (state_d == ST_IDLE);

        // Latch the request and clear the previous result so stores/errors return 0.
        if (accept_s) begin
            rw_d          = req_if.req_rw;
            mode_d        = req_if.req_mode;
            sgn_d         = req_if.req_signed;
            addr_d        = req_if.req_addr;
            wdata_hi_d    = req_if.req_wdata_hi;
            rsp_err_d     = req_err_s;
            rsp_data_d    = 32'd0;
            rsp_data_hi_d = 32'd0;
        end else begin
            rw_d          = rw_q;
            addr_d        = addr_q;
        end

        // ram_dout is valid at the end of a beat cycle; capture it on that edge.
        if ((state_q == ST_BEAT0) && !rw_q) begin
            rsp_data_d    = ext_s;
        end else if ((state_q == ST_BEAT1) && !rw_q) begin
            rsp_data_hi_d = ram_if.ram_dout;
        end else begin
            rsp_data_d    = rsp_data_d;
        end

        case (state_d)
            // BEAT0 is only entered from IDLE, so the live request fields are used.
            ST_BEAT0: begin
                ram_en_d   = 1'b1;
                ram_rw_d   = req_if.req_rw;
                ram_addr_d = req_if.req_addr;
                ram_din_d  = req_if.req_wdata;
                ram_mode_d = (req_if.req_mode == MODE_DWORD) ? MODE_WORD : req_if.req_mode;
            end
            ST_BEAT1: begin
                ram_en_d   = 1'b1;
                ram_rw_d   = rw_q;
                ram_addr_d = addr_q + 32'd4;
                ram_din_d  = wdata_hi_q;
                ram_mode_d = MODE_WORD;
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
            end
            default: begin
                ram_en_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rw_q          <= 1'b0;
            mode_q        <= MODE_BYTE;
            sgn_q         <= 1'b0;
            addr_q        <= 32'd0;
            wdata_hi_q    <= 32'd0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_data_hi_q <= 32'd0;
            ram_en_q      <= 1'b0;
            ram_rw_q      <= 1'b0;
            ram_mode_q    <= MODE_BYTE;
            ram_addr_q    <= 32'd0;
            ram_din_q     <= 32'd0;
        end else begin
            rw_q          <= rw_d;
            mode_q        <= mode_d;
            sgn_q         <= sgn_d;
            addr_q        <= addr_d;
            wdata_hi_q    <= wdata_hi_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_data_q    <= rsp_data_d;
            rsp_data_hi_q <= rsp_data_hi_d;
            ram_en_q      <= ram_en_d;
            ram_rw_q      <= ram_rw_d;
            ram_mode_q    <= ram_mode_d;
            ram_addr_q    <= ram_addr_d;
            ram_din_q     <= ram_din_d;
        end
    end

    assign req_if.req_ready   = req_ready_q;
    assign req_if.stall       = ~req_ready_q;
    assign req_if.rsp_valid   = rsp_valid_q;
    assign req_if.rsp_err     = rsp_err_q;
    assign req_if.rsp_data    = rsp_data_q;
    assign req_if.rsp_data_hi = rsp_data_hi_q;

    assign ram_if.ram_en   = ram_en_q;
    assign ram_if.ram_rw   = ram_rw_q;
    assign ram_if.ram_mode = ram_mode_q;
    assign ram_if.ram_addr = ram_addr_q;
    assign ram_if.ram_din  = ram_din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench: a byte-array RAM attached to the controller, a transaction
// level model that predicts every cycle of the pin/response behaviour, a
// per-cycle compare process, and literal expectations for each scenario.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if req_bus ();
    mem_ram_if         ram_bus ();

    mem_access_ctrl #(.MEM_BYTES(256)) dut (
        .clk    (clk),
        .clr    (clr),
        .req_if (req_bus),
        .ram_if (ram_bus)
    );

    // ---------------- RAM attached to the DUT ----------------
    logic [7:0] ram_mem [256] = '{default: 8'h00};
    logic [7:0] ram_a;

    // Read data is only meaningful while enabled; garbage otherwise.
    always_comb begin
        ram_a = ram_bus.ram_addr[7:0];
        if (!ram_bus.ram_en) begin
            ram_bus.ram_dout = 32'hA5A5_A5A5;
        end else begin
            case (ram_bus.ram_mode)
                2'b00:   ram_bus.ram_dout = {24'd0, ram_mem[ram_a]};
                2'b01:   ram_bus.ram_dout = {16'd0, ram_mem[ram_a + 8'd1], ram_mem[ram_a]};
                default: ram_bus.ram_dout = {ram_mem[ram_a + 8'd3], ram_mem[ram_a + 8'd2],
                                             ram_mem[ram_a + 8'd1], ram_mem[ram_a]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (ram_bus.ram_en && ram_bus.ram_rw) begin
            ram_mem[ram_a] <= ram_bus.ram_din[7:0];
            if (ram_bus.ram_mode != 2'b00) ram_mem[ram_a + 8'd1] <= ram_bus.ram_din[15:8];
            if (ram_bus.ram_mode[1]) begin
                ram_mem[ram_a + 8'd2] <= ram_bus.ram_din[23:16];
                ram_mem[ram_a + 8'd3] <= ram_bus.ram_din[31:24];
            end
        end
    end

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic        ready;
        logic        en;
        logic        rw;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] din;
        logic        valid;
        logic        err;
        logic [31:0] data;
        logic [31:0] hi;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] last_addr, last_din;
    logic [7:0]  mm [256] = '{default: 8'h00};

    function automatic exp_t idle_exp(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e = '0;
        e.ready = 1'b1;
        e.addr  = a;
        e.din   = d;
        return e;
    endfunction

    function automatic logic [31:0] word_at(input logic [7:0] b);
        return {mm[b + 8'd3], mm[b + 8'd2], mm[b + 8'd1], mm[b]};
    endfunction

    task automatic model_write(input exp_t e);
        logic [7:0] b;
        b = e.addr[7:0];
        mm[b] <= e.din[7:0];
        if (e.mode != 2'b00) mm[b + 8'd1] <= e.din[15:8];
        if (e.mode[1]) begin
            mm[b + 8'd2] <= e.din[23:16];
            mm[b + 8'd3] <= e.din[31:24];
        end
    endtask

    // Expand one accepted request into its expected cycle-by-cycle timeline.
    task automatic model_accept(inout logic [31:0] la, inout logic [31:0] ld);
        exp_t        e;
        logic [31:0] a, lo, hi;
        logic [63:0] last_byte;
        logic [1:0]  m;
        logic        mis;
        a = req_bus.req_addr;
        m = req_bus.req_mode;
        last_byte = 64'(a) + (64'd1 << m) - 64'd1;
        mis = ((m == 2'b01) && a[0]) || (m[1] && (a[1:0] != 2'b00));
        if (mis || (last_byte >= 64'd256)) begin
            e = idle_exp(la, ld);
            e.ready = 1'b0;
            e.valid = 1'b1;
            e.err   = 1'b1;
            q.push_back(e);
        end else begin
            lo = 32'd0;
            hi = 32'd0;
            if (!req_bus.req_rw) begin
                case (m)
                    2'b00: begin
                        lo = {24'd0, mm[a[7:0]]};
                        if (req_bus.req_signed && lo[7]) lo = lo | 32'hFFFF_FF00;
                    end
                    2'b01: begin
                        lo = {16'd0, mm[a[7:0] + 8'd1], mm[a[7:0]]};
                        if (req_bus.req_signed && lo[15]) lo = lo | 32'hFFFF_0000;
                    end
                    2'b10: lo = word_at(a[7:0]);
                    default: begin
                        lo = word_at(a[7:0]);
                        hi = word_at(a[7:0] + 8'd4);
                    end
                endcase
            end
            e = idle_exp(a, req_bus.req_wdata);
            e.ready = 1'b0;
            e.en    = 1'b1;
            e.rw    = req_bus.req_rw;
            e.mode  = (m == 2'b11) ? 2'b10 : m;
            q.push_back(e);
            la = a;
            ld = req_bus.req_wdata;
            if (m == 2'b11) begin
                e = idle_exp(la, ld);
                e.ready = 1'b0;
                q.push_back(e);
                la = a + 32'd4;
                ld = req_bus.req_wdata_hi;
                e = idle_exp(la, ld);
                e.ready = 1'b0;
                e.en    = 1'b1;
                e.rw    = req_bus.req_rw;
                e.mode  = 2'b10;
                q.push_back(e);
            end
            e = idle_exp(la, ld);
            e.ready = 1'b0;
            e.valid = 1'b1;
            e.data  = lo;
            e.hi    = hi;
            q.push_back(e);
        end
    endtask

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            q.delete();
            cur       <= idle_exp(32'd0, 32'd0);
            last_addr <= 32'd0;
            last_din  <= 32'd0;
        end else begin : model_step
            logic [31:0] la, ld;
            la = last_addr;
            ld = last_din;
            if (cur.en && cur.rw) model_write(cur);
            if (cur.ready && req_bus.req_valid) model_accept(la, ld);
            if (q.size() > 0) cur <= q.pop_front();
            else              cur <= idle_exp(la, ld);
            last_addr <= la;
            last_din  <= ld;
        end
    end

    // ---------------- checking ----------------
    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_bus.req_ready), 32'(cur.ready));
            check("stall",     32'(req_bus.stall),     32'(!cur.ready));
            check("ram_en",    32'(ram_bus.ram_en),    32'(cur.en));
            check("ram_rw",    32'(ram_bus.ram_rw),    32'(cur.rw));
            check("ram_mode",  32'(ram_bus.ram_mode),  32'(cur.mode));
            check("ram_addr",  ram_bus.ram_addr,       cur.addr);
            check("ram_din",   ram_bus.ram_din,        cur.din);
            check("rsp_valid", 32'(req_bus.rsp_valid), 32'(cur.valid));
            if (cur.valid) begin
                check("rsp_err",     32'(req_bus.rsp_err), 32'(cur.err));
                check("rsp_data",    req_bus.rsp_data,     cur.data);
                check("rsp_data_hi", req_bus.rsp_data_hi,  cur.hi);
            end
        end
    end

    // ---------------- stimulus ----------------
    int          lat;
    logic        err;
    logic [31:0] d, dh, a1, a3;
    logic [7:0]  en_pat;
    logic [1:0]  m1;

    // Issue one request from an IDLE cycle; en_pat[k] is ram_en in cycle k after accept.
    task automatic send(input logic rw, input logic [1:0] mode, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] wdh);
        req_bus.req_valid    = 1'b1;
        req_bus.req_rw       = rw;
        req_bus.req_mode     = mode;
        req_bus.req_signed   = sgn;
        req_bus.req_addr     = addr;
        req_bus.req_wdata    = wd;
        req_bus.req_wdata_hi = wdh;
        @(posedge clk);
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        lat = 0; err = 1'b0; d = 32'd0; dh = 32'd0;
        en_pat = 8'd0; a1 = 32'd0; a3 = 32'd0; m1 = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            en_pat[k] = ram_bus.ram_en;
            if (k == 1) begin
                a1 = ram_bus.ram_addr;
                m1 = ram_bus.ram_mode;
            end
            if (k == 3) a3 = ram_bus.ram_addr;
            if (req_bus.rsp_valid) begin
                lat = k;
                err = req_bus.rsp_err;
                d   = req_bus.rsp_data;
                dh  = req_bus.rsp_data_hi;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) check("rsp_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        req_bus.req_valid    = 1'b0;
        req_bus.req_rw       = 1'b0;
        req_bus.req_mode     = 2'b00;
        req_bus.req_signed   = 1'b0;
        req_bus.req_addr     = 32'd0;
        req_bus.req_wdata    = 32'd0;
        req_bus.req_wdata_hi = 32'd0;
        #2 clr = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("rst_ready",    32'(req_bus.req_ready), 32'd1);
        check("rst_stall",    32'(req_bus.stall),     32'd0);
        check("rst_ram_en",   32'(ram_bus.ram_en),    32'd0);
        check("rst_ram_addr", ram_bus.ram_addr,       32'd0);
        check("rst_rsp_data", req_bus.rsp_data,       32'd0);

        // Word store then load at 0x10.
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'd0);
        check("wst_lat",  32'(lat),    32'd2);
        check("wst_en",   32'(en_pat), 32'h02);
        check("wst_mode", 32'(m1),     32'd2);
        check("wst_data", d,           32'd0);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'd0);
        check("wld_lat",  32'(lat), 32'd2);
        check("wld_data", d,        32'hDEAD_BEEF);

        // Halfword loads of the low half 0xBEEF.
        send(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 32'd0);
        check("hld_s", d, 32'hFFFF_BEEF);
        send(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 32'd0);
        check("hld_u", d, 32'h0000_BEEF);

        // Byte 0x80 at 0x21, signed and unsigned loads.
        send(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0080, 32'd0);
        send(1'b0, 2'b00, 1'b1, 32'h21, 32'd0, 32'd0);
        check("bld_s", d, 32'hFFFF_FF80);
        send(1'b0, 2'b00, 1'b0, 32'h21, 32'd0, 32'd0);
        check("bld_u", d, 32'h0000_0080);

        // Doubleword store then load at 0x40.
        send(1'b1, 2'b11, 1'b0, 32'h40, 32'h1111_1111, 32'h2222_2222);
        check("dst_en",  32'(en_pat), 32'h0A);
        check("dst_a0",  a1,          32'h40);
        check("dst_a1",  a3,          32'h44);
        check("dst_lat", 32'(lat),    32'd4);
        send(1'b0, 2'b11, 1'b0, 32'h40, 32'd0, 32'd0);
        check("dld_lat", 32'(lat), 32'd4);
        check("dld_lo",  d,        32'h1111_1111);
        check("dld_hi",  dh,       32'h2222_2222);

        // Misaligned halfword.
        send(1'b0, 2'b01, 1'b0, 32'h03, 32'd0, 32'd0);
        check("mis_lat",  32'(lat),    32'd1);
        check("mis_err",  32'(err),    32'd1);
        check("mis_data", d,           32'd0);
        check("mis_en",   32'(en_pat), 32'h00);

        // Range boundary cases.
        send(1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFE_F00D, 32'd0);
        check("fc_err", 32'(err), 32'd0);
        send(1'b0, 2'b10, 1'b0, 32'hFC, 32'd0, 32'd0);
        check("fc_data", d, 32'hCAFE_F00D);
        send(1'b0, 2'b10, 1'b0, 32'hFE, 32'd0, 32'd0);
        check("fe_err", 32'(err), 32'd1);
        send(1'b1, 2'b11, 1'b0, 32'hFC, 32'h1234_5678, 32'h9ABC_DEF0);
        check("dfc_err", 32'(err),    32'd1);
        check("dfc_en",  32'(en_pat), 32'h00);
        check("dfc_lat", 32'(lat),    32'd1);

        // Reset during the GAP of a doubleword store.
        req_bus.req_valid    = 1'b1;
        req_bus.req_rw       = 1'b1;
        req_bus.req_mode     = 2'b11;
        req_bus.req_signed   = 1'b0;
        req_bus.req_addr     = 32'h80;
        req_bus.req_wdata    = 32'hAAAA_5555;
        req_bus.req_wdata_hi = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        @(negedge clk);
        check("gap_ready", 32'(req_bus.req_ready), 32'd0);
        #1 clr = 1'b0;
        #1;
        check("rst_mid_en",    32'(ram_bus.ram_en),    32'd0);
        check("rst_mid_ready", 32'(req_bus.req_ready), 32'd1);
        check("rst_mid_valid", 32'(req_bus.rsp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_w0", {ram_mem[8'h83], ram_mem[8'h82], ram_mem[8'h81], ram_mem[8'h80]}, 32'hAAAA_5555);
        check("abort_w1", {ram_mem[8'h87], ram_mem[8'h86], ram_mem[8'h85], ram_mem[8'h84]}, 32'h0000_0000);
        send(1'b0, 2'b11, 1'b0, 32'h80, 32'd0, 32'd0);
        check("abort_ld_lo", d,  32'hAAAA_5555);
        check("abort_ld_hi", dh, 32'h0000_0000);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
